// File: rtl/smi_mem_port_switch_pkg.sv
// Shared SMI definitions: frame type IDs, request-type decode and the
// state encodings of the memory port switch FSMs.
package smi_mem_port_switch_pkg;

  localparam logic [7:0] READ_REQ_ID   = 8'h01;
  localparam logic [7:0] WRITE_REQ_ID  = 8'h02;
  localparam logic [7:0] READ_RESP_ID  = 8'hFD;
  localparam logic [7:0] WRITE_RESP_ID = 8'hFE;

  typedef enum logic [1:0] {
    ReqTypeRead    = 2'd0,
    ReqTypeWrite   = 2'd1,
    ReqTypeUnknown = 2'd2
  } reqType_t;

  localparam logic [1:0] ReqIdle    = 2'd0;
  localparam logic [1:0] ReqRead    = 2'd1;
  localparam logic [1:0] ReqWrite   = 2'd2;
  localparam logic [1:0] ReqDiscard = 2'd3;

  localparam logic [1:0] RespIdle  = 2'd0;
  localparam logic [1:0] RespRead  = 2'd1;
  localparam logic [1:0] RespWrite = 2'd2;

  function automatic reqType_t decodeReqType(input logic [7:0] id);
    case (id)
      READ_REQ_ID:  return ReqTypeRead;
      WRITE_REQ_ID: return ReqTypeWrite;
      default:      return ReqTypeUnknown;
    endcase
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry SMI skid buffer: one cycle from input transfer to output Ready,
// one flit per cycle when unstalled; inStop is registered (skid entry full).
module smi_skid_buffer #(
  parameter int DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 inReady,
  input  logic [7:0]           inEofc,
  input  logic [DataWidth-1:0] inData,
  output logic                 inStop,
  output logic                 outReady,
  output logic [7:0]           outEofc,
  output logic [DataWidth-1:0] outData,
  input  logic                 outStop
);

  logic                 mainVld;
  logic                 skidVld;
  logic [7:0]           mainEofc;
  logic [7:0]           skidEofc;
  logic [DataWidth-1:0] mainData;
  logic [DataWidth-1:0] skidData;
  logic                 inXfer;
  logic                 mainFree;

  assign inXfer   = inReady & ~skidVld;
  assign mainFree = ~mainVld | ~outStop;

  always_ff @(posedge clk) begin
    if (srst) begin
      mainVld <= 1'b0;
      skidVld <= 1'b0;
    end else if (mainFree) begin
      mainVld <= skidVld | inXfer;
      skidVld <= 1'b0;
    end else if (inXfer) begin
      skidVld <= 1'b1;
    end
  end

  // Payload registers carry no reset; validity lives only in the control flops.
  always_ff @(posedge clk) begin
    if (mainFree) begin
      if (skidVld) begin
        mainEofc <= skidEofc;
        mainData <= skidData;
      end else if (inXfer) begin
        mainEofc <= inEofc;
        mainData <= inData;
      end
    end else if (inXfer) begin
      skidEofc <= inEofc;
      skidData <= inData;
    end
  end

  assign inStop   = skidVld;
  assign outReady = mainVld;
  assign outEofc  = mainEofc;
  assign outData  = mainData;

endmodule

// File: rtl/smi_mem_port_switch.sv
// Routes SMI request frames to read/write streams by type byte, drops unknown
// frames, and round-robin merges read/write response frames without interleave.
module smi_mem_port_switch
  import smi_mem_port_switch_pkg::*;
#(
  parameter int DataIndexSize = 4,
  parameter int DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 rdReqReady,
  output logic [7:0]           rdReqEofc,
  output logic [DataWidth-1:0] rdReqData,
  input  logic                 rdReqStop,
  output logic                 wrReqReady,
  output logic [7:0]           wrReqEofc,
  output logic [DataWidth-1:0] wrReqData,
  input  logic                 wrReqStop,
  input  logic                 rdRespReady,
  input  logic [7:0]           rdRespEofc,
  input  logic [DataWidth-1:0] rdRespData,
  output logic                 rdRespStop,
  input  logic                 wrRespReady,
  input  logic [7:0]           wrRespEofc,
  input  logic [DataWidth-1:0] wrRespData,
  output logic                 wrRespStop,
  output logic                 smiRespReady,
  output logic [7:0]           smiRespEofc,
  output logic [DataWidth-1:0] smiRespData,
  input  logic                 smiRespStop,
  output logic [15:0]          dropCount
);

  logic [1:0]  reqState;
  logic [15:0] dropCnt;
  reqType_t    reqRoute;
  logic        rdBufStop;
  logic        wrBufStop;
  logic        reqXfer;
  logic        reqLast;

  // Mid-frame the FSM state decides the route; the type byte is only looked at on a first flit.
  always_comb begin
    reqRoute = ReqTypeUnknown;
    case (reqState)
      ReqIdle:  reqRoute = decodeReqType(smiReqData[7:0]);
      ReqRead:  reqRoute = ReqTypeRead;
      ReqWrite: reqRoute = ReqTypeWrite;
      default:  reqRoute = ReqTypeUnknown;
    endcase
  end

  always_comb begin
    smiReqStop = 1'b0;
    case (reqRoute)
      ReqTypeRead:  smiReqStop = rdBufStop;
      ReqTypeWrite: smiReqStop = wrBufStop;
      default:      smiReqStop = 1'b0;
    endcase
  end

  assign reqXfer = smiReqReady & ~smiReqStop;
  assign reqLast = (smiReqEofc != 8'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      reqState <= ReqIdle;
      dropCnt  <= 16'd0;
    end else if (reqXfer) begin
      if (reqState == ReqIdle) begin
        if (!reqLast) begin
          case (reqRoute)
            ReqTypeRead:  reqState <= ReqRead;
            ReqTypeWrite: reqState <= ReqWrite;
            default:      reqState <= ReqDiscard;
          endcase
        end
        if (reqRoute == ReqTypeUnknown && dropCnt != 16'hFFFF) begin
          dropCnt <= dropCnt + 16'd1;
        end
      end else if (reqLast) begin
        reqState <= ReqIdle;
      end
    end
  end

  assign dropCount = dropCnt;

  smi_skid_buffer #(.DataWidth(DataWidth)) rdReqBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (smiReqReady && reqRoute == ReqTypeRead),
    .inEofc   (smiReqEofc),
    .inData   (smiReqData),
    .inStop   (rdBufStop),
    .outReady (rdReqReady),
    .outEofc  (rdReqEofc),
    .outData  (rdReqData),
    .outStop  (rdReqStop)
  );

  smi_skid_buffer #(.DataWidth(DataWidth)) wrReqBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (smiReqReady && reqRoute == ReqTypeWrite),
    .inEofc   (smiReqEofc),
    .inData   (smiReqData),
    .inStop   (wrBufStop),
    .outReady (wrReqReady),
    .outEofc  (wrReqEofc),
    .outData  (wrReqData),
    .outStop  (wrReqStop)
  );

  logic [1:0]           respState;
  logic                 preferWrite;
  logic                 grantRd;
  logic                 grantWr;
  logic                 respInReady;
  logic [7:0]           respInEofc;
  logic [DataWidth-1:0] respInData;
  logic                 respInStop;
  logic                 respXfer;
  logic                 respLast;

  // Idle grants only to an input that is offering a flit, so a single-flit frame never leaves Idle.
  always_comb begin
    grantRd = 1'b0;
    grantWr = 1'b0;
    case (respState)
      RespRead:  grantRd = 1'b1;
      RespWrite: grantWr = 1'b1;
      default: begin
        if (rdRespReady && (!wrRespReady || !preferWrite)) begin
          grantRd = 1'b1;
        end else if (wrRespReady) begin
          grantWr = 1'b1;
        end
      end
    endcase
  end

  assign respInReady = (grantRd & rdRespReady) | (grantWr & wrRespReady);
  assign respInEofc  = grantWr ? wrRespEofc : rdRespEofc;
  assign respInData  = grantWr ? wrRespData : rdRespData;
  assign rdRespStop  = ~grantRd | respInStop;
  assign wrRespStop  = ~grantWr | respInStop;
  assign respXfer    = respInReady & ~respInStop;
  assign respLast    = (respInEofc != 8'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      respState   <= RespIdle;
      preferWrite <= 1'b0;
    end else if (respXfer) begin
      if (respState == RespIdle) begin
        preferWrite <= grantRd;
        if (!respLast) begin
          respState <= grantWr ? RespWrite : RespRead;
        end
      end else if (respLast) begin
        respState <= RespIdle;
      end
    end
  end

  smi_skid_buffer #(.DataWidth(DataWidth)) respBuf (
    .clk      (clk),
    .srst     (srst),
    .inReady  (respInReady),
    .inEofc   (respInEofc),
    .inData   (respInData),
    .inStop   (respInStop),
    .outReady (smiRespReady),
    .outEofc  (smiRespEofc),
    .outData  (smiRespData),
    .outStop  (smiRespStop)
  );

endmodule

// File: tb/tb_smi_mem_port_switch.sv
// Scoreboarded bench for smi_mem_port_switch: frame-level reference model for
// request routing/drop counting and per-source response queues for merging.
module tb_smi_mem_port_switch;
  import smi_mem_port_switch_pkg::*;

  localparam int DW = 128;

  typedef struct {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
    int            gap;
    int            cyc;
    bit            lat;
  } flit_t;

  logic          clk;
  logic          srst;
  logic          smiReqReady;
  logic [7:0]    smiReqEofc;
  logic [DW-1:0] smiReqData;
  logic          smiReqStop;
  logic          rdReqReady, wrReqReady, smiRespReady;
  logic [7:0]    rdReqEofc, wrReqEofc, smiRespEofc;
  logic [DW-1:0] rdReqData, wrReqData, smiRespData;
  logic          rdReqStop, wrReqStop, smiRespStop;
  logic          rdRespReady, wrRespReady, rdRespStop, wrRespStop;
  logic [7:0]    rdRespEofc, wrRespEofc;
  logic [DW-1:0] rdRespData, wrRespData;
  logic [15:0]   dropCount;

  logic          rsReady [2];
  logic [7:0]    rsEofc  [2];
  logic [DW-1:0] rsData  [2];
  logic          rsStop  [2];
  logic          oReady  [2];
  logic [7:0]    oEofc   [2];
  logic [DW-1:0] oData   [2];
  logic          oStop   [2];

  assign rdRespReady = rsReady[0];
  assign rdRespEofc  = rsEofc[0];
  assign rdRespData  = rsData[0];
  assign wrRespReady = rsReady[1];
  assign wrRespEofc  = rsEofc[1];
  assign wrRespData  = rsData[1];
  assign rsStop[0]   = rdRespStop;
  assign rsStop[1]   = wrRespStop;
  assign oReady[0]   = rdReqReady;
  assign oEofc[0]    = rdReqEofc;
  assign oData[0]    = rdReqData;
  assign oStop[0]    = rdReqStop;
  assign oReady[1]   = wrReqReady;
  assign oEofc[1]    = wrReqEofc;
  assign oData[1]    = wrReqData;
  assign oStop[1]    = wrReqStop;

  smi_mem_port_switch dut (
    .clk          (clk),
    .srst         (srst),
    .smiReqReady  (smiReqReady),
    .smiReqEofc   (smiReqEofc),
    .smiReqData   (smiReqData),
    .smiReqStop   (smiReqStop),
    .rdReqReady   (rdReqReady),
    .rdReqEofc    (rdReqEofc),
    .rdReqData    (rdReqData),
    .rdReqStop    (rdReqStop),
    .wrReqReady   (wrReqReady),
    .wrReqEofc    (wrReqEofc),
    .wrReqData    (wrReqData),
    .wrReqStop    (wrReqStop),
    .rdRespReady  (rdRespReady),
    .rdRespEofc   (rdRespEofc),
    .rdRespData   (rdRespData),
    .rdRespStop   (rdRespStop),
    .wrRespReady  (wrRespReady),
    .wrRespEofc   (wrRespEofc),
    .wrRespData   (wrRespData),
    .wrRespStop   (wrRespStop),
    .smiRespReady (smiRespReady),
    .smiRespEofc  (smiRespEofc),
    .smiRespData  (smiRespData),
    .smiRespStop  (smiRespStop),
    .dropCount    (dropCount)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  flit_t reqFeed[$];
  flit_t respFeed[2][$];
  flit_t reqExpQ[2][$];
  flit_t respExpQ[2][$];
  int    orderQ[$];
  bit    reqHave = 0;
  bit    respHave[2] = '{0, 0};
  int    reqAccCnt = 0;
  int    respAccCnt[2] = '{0, 0};
  int    outCnt[2] = '{0, 0};
  int    curType = 0;   // 0 between frames, else 1 read, 2 write, 3 unknown
  int    expDrop = 0;
  bit    latChk = 0;
  bit    b2b = 0;
  int    respPrevCyc = -1;
  bit    randStops = 0;
  logic  rdStopVal = 0, wrStopVal = 0, respStopVal = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int classify(input logic [7:0] b);
    if (b == READ_REQ_ID) return 1;
    if (b == WRITE_REQ_ID) return 2;
    return 3;
  endfunction

  function automatic logic [DW-1:0] rndData();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stop inputs: either held at directed values or randomly toggled each cycle.
  initial begin
    rdReqStop = 0; wrReqStop = 0; smiRespStop = 0;
    forever begin
      @(negedge clk);
      if (randStops) begin
        rdReqStop   = ($urandom_range(3) == 0);
        wrReqStop   = ($urandom_range(3) == 0);
        smiRespStop = ($urandom_range(3) == 0);
      end else begin
        rdReqStop   = rdStopVal;
        wrReqStop   = wrStopVal;
        smiRespStop = respStopVal;
      end
    end
  end

  // Request driver; the frame-level model runs on every accepted flit.
  initial begin
    flit_t cur;
    flit_t e;
    int gapLeft = 0;
    int stall = 0;
    int t;
    smiReqReady = 0; smiReqEofc = 0; smiReqData = '0;
    forever begin
      @(negedge clk);
      if (!reqHave && reqFeed.size() != 0) begin
        cur = reqFeed.pop_front();
        reqHave = 1; gapLeft = cur.gap; stall = 0;
      end
      if (reqHave && gapLeft > 0) begin
        gapLeft--;
        smiReqReady = 0;
      end else if (reqHave) begin
        smiReqReady = 1; smiReqEofc = cur.eofc; smiReqData = cur.data;
        #4;
        t = (curType != 0) ? curType : classify(cur.data[7:0]);
        if (t == 3) chk("discard_stop", smiReqStop, 0);
        if (!smiReqStop) begin
          if (curType == 0 && t == 3) expDrop = (expDrop == 65535) ? 65535 : expDrop + 1;
          e = cur; e.cyc = cyc; e.lat = latChk;
          if (t == 1) reqExpQ[0].push_back(e);
          if (t == 2) reqExpQ[1].push_back(e);
          curType = (cur.eofc != 0) ? 0 : t;
          reqAccCnt++;
          reqHave = 0;
        end else if (++stall > 1000) begin
          checks++; errors++;
          $display("FAIL req_accept_timeout actual=stalled required=accepted");
          reqHave = 0;
        end
      end else begin
        smiReqReady = 0;
      end
    end
  end

  task automatic respDriver(input int s);
    flit_t cur;
    int gapLeft = 0;
    int stall = 0;
    rsReady[s] = 0; rsEofc[s] = 0; rsData[s] = '0;
    forever begin
      @(negedge clk);
      if (!respHave[s] && respFeed[s].size() != 0) begin
        cur = respFeed[s].pop_front();
        respHave[s] = 1; gapLeft = cur.gap; stall = 0;
      end
      if (respHave[s] && gapLeft > 0) begin
        gapLeft--;
        rsReady[s] = 0;
      end else if (respHave[s]) begin
        rsReady[s] = 1; rsEofc[s] = cur.eofc; rsData[s] = cur.data;
        #4;
        if (!rsStop[s]) begin
          respExpQ[s].push_back(cur);
          respAccCnt[s]++;
          respHave[s] = 0;
        end else if (++stall > 1000) begin
          checks++; errors++;
          $display("FAIL resp%0d_accept_timeout actual=stalled required=accepted", s);
          respHave[s] = 0;
        end
      end else begin
        rsReady[s] = 0;
      end
    end
  endtask

  initial respDriver(0);
  initial respDriver(1);

  task automatic reqMonitor(input int s);
    flit_t e;
    string nm;
    nm = (s == 0) ? "rdReq" : "wrReq";
    forever begin
      @(negedge clk);
      #4;
      if (!srst && oReady[s] && !oStop[s]) begin
        outCnt[s]++;
        if (reqExpQ[s].size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_unexpected actual=eofc %0d data %0h required=no flit", nm, oEofc[s], oData[s]);
        end else begin
          e = reqExpQ[s].pop_front();
          chk({nm, "_eofc"}, oEofc[s], e.eofc);
          chk({nm, "_data"}, oData[s], e.data);
          if (e.lat) chk({nm, "_latency"}, cyc, e.cyc + 1);
        end
      end
    end
  endtask

  initial reqMonitor(0);
  initial reqMonitor(1);

  // Response monitor: the first flit's ID byte names the source; the rest of the frame must follow from that same source.
  initial begin
    int src = -1;
    flit_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!srst && smiRespReady && !smiRespStop) begin
        if (src < 0) begin
          src = (smiRespData[7:0] == READ_RESP_ID) ? 0 : (smiRespData[7:0] == WRITE_RESP_ID) ? 1 : -1;
          if (src < 0) begin
            checks++; errors++;
            $display("FAIL resp_id actual=%0h required=FD or FE", smiRespData[7:0]);
          end else if (orderQ.size() != 0) begin
            chk("resp_order", src, orderQ.pop_front());
          end
        end
        if (src >= 0) begin
          if (respExpQ[src].size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected actual=data %0h required=no flit", smiRespData);
          end else begin
            e = respExpQ[src].pop_front();
            chk("resp_eofc", smiRespEofc, e.eofc);
            chk("resp_data", smiRespData, e.data);
          end
        end
        if (b2b && respPrevCyc >= 0) chk("resp_back_to_back", cyc, respPrevCyc + 1);
        respPrevCyc = cyc;
        if (smiRespEofc != 0) src = -1;
      end
    end
  end

  task automatic pushReq(input logic [7:0] id, input int n, input logic [7:0] lastEofc, input int gapMax);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.data = rndData();
      if (k == 0) f.data[7:0] = id;
      f.eofc = (k == n - 1) ? lastEofc : 8'd0;
      f.gap  = $urandom_range(gapMax);
      f.cyc  = 0; f.lat = 0;
      reqFeed.push_back(f);
    end
  endtask

  task automatic pushResp(input int s, input int n, input logic [7:0] lastEofc, input int gapMin, input int gapMax);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.data = rndData();
      if (k == 0) f.data[7:0] = (s == 0) ? READ_RESP_ID : WRITE_RESP_ID;
      f.eofc = (k == n - 1) ? lastEofc : 8'd0;
      f.gap  = $urandom_range(gapMax, gapMin);
      f.cyc  = 0; f.lat = 0;
      respFeed[s].push_back(f);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (n < budget && !(reqFeed.size() == 0 && !reqHave && respFeed[0].size() == 0 &&
           respFeed[1].size() == 0 && !respHave[0] && !respHave[1] && reqExpQ[0].size() == 0 &&
           reqExpQ[1].size() == 0 && respExpQ[0].size() == 0 && respExpQ[1].size() == 0)) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=pending required=drained");
    end
    tick(3);
  endtask

  initial begin
    int rd0, wr0, base, n, ty;
    logic [7:0] b;
    flit_t f;
    srst = 1;
    tick(3);
    chk("reset_rdReqReady", rdReqReady, 0);
    chk("reset_wrReqReady", wrReqReady, 0);
    chk("reset_smiRespReady", smiRespReady, 0);
    chk("reset_dropCount", dropCount, 0);
    srst = 0;
    tick(2);

    // Continuous single-flit responses on both inputs alternate, read first.
    b2b = 1; respPrevCyc = -1;
    for (int i = 0; i < 6; i++) begin
      pushResp(0, 1, 8'd4, 0, 0);
      pushResp(1, 1, 8'd4, 0, 0);
      orderQ.push_back(0);
      orderQ.push_back(1);
    end
    waitIdle(500);
    b2b = 0;
    chk("resp_order_consumed", orderQ.size(), 0);

    // Write response arriving mid read frame waits for the read's final flit.
    base = respAccCnt[0];
    pushResp(0, 3, 8'd16, 3, 3);
    orderQ.push_back(0);
    orderQ.push_back(1);
    n = 0;
    while (respAccCnt[0] < base + 1 && n < 200) begin tick(1); n++; end
    pushResp(1, 2, 8'd5, 0, 0);
    waitIdle(500);

    // 3-flit write request passes through with one cycle latency.
    latChk = 1;
    rd0 = outCnt[0]; wr0 = outCnt[1];
    pushReq(WRITE_REQ_ID, 3, 8'd16, 0);
    waitIdle(500);
    latChk = 0;
    chk("write_rdReq_idle", outCnt[0], rd0);
    chk("write_wrReq_flits", outCnt[1], wr0 + 3);
    chk("write_dropCount", dropCount, 0);

    // Unknown frames vanish and count once each.
    rd0 = outCnt[0]; wr0 = outCnt[1];
    pushReq(8'h55, 1, 8'd7, 0);
    pushReq(8'h55, 4, 8'd16, 0);
    waitIdle(500);
    chk("unknown_rdReq_idle", outCnt[0], rd0);
    chk("unknown_wrReq_idle", outCnt[1], wr0);
    chk("unknown_dropCount", dropCount, 2);

    // Read output stalled: following write frame must wait behind it.
    rdStopVal = 1;
    wr0 = outCnt[1]; rd0 = outCnt[0];
    pushReq(READ_REQ_ID, 3, 8'd16, 0);
    pushReq(WRITE_REQ_ID, 2, 8'd9, 0);
    tick(15);
    chk("stall_wrReq_held", outCnt[1], wr0);
    chk("stall_smiReqStop", smiReqStop, 1);
    chk("stall_pending_flits", reqFeed.size() + (reqHave ? 1 : 0), 3);
    rdStopVal = 0;
    waitIdle(500);
    chk("stall_rdReq_flits", outCnt[0], rd0 + 3);
    chk("stall_wrReq_flits", outCnt[1], wr0 + 2);

    // Reset after 2nd flit of a 4-flit frame; the 3rd flit starts a new write frame.
    rdStopVal = 1;
    tick(1);
    base = reqAccCnt;
    f.eofc = 0; f.gap = 0; f.cyc = 0; f.lat = 0;
    f.data = rndData(); f.data[7:0] = READ_REQ_ID; reqFeed.push_back(f);
    f.data = rndData(); reqFeed.push_back(f);
    n = 0;
    while (reqAccCnt < base + 2 && n < 200) begin tick(1); n++; end
    srst = 1;
    tick(1);
    chk("srst_rdReqReady", rdReqReady, 0);
    chk("srst_wrReqReady", wrReqReady, 0);
    chk("srst_smiRespReady", smiRespReady, 0);
    chk("srst_dropCount", dropCount, 0);
    srst = 0;
    reqExpQ[0].delete();
    reqExpQ[1].delete();
    curType = 0;
    expDrop = 0;
    rdStopVal = 0;
    rd0 = outCnt[0]; wr0 = outCnt[1];
    latChk = 1;
    f.data = rndData(); f.data[7:0] = WRITE_REQ_ID; f.eofc = 0; reqFeed.push_back(f);
    f.data = rndData(); f.eofc = 8'd12; reqFeed.push_back(f);
    waitIdle(500);
    latChk = 0;
    chk("srst_new_write_flits", outCnt[1], wr0 + 2);
    chk("srst_rdReq_idle", outCnt[0], rd0);

    // Randomized traffic with random backpressure on every output.
    randStops = 1;
    for (int i = 0; i < 40; i++) begin
      ty = $urandom_range(9);
      if (ty < 4) b = READ_REQ_ID;
      else if (ty < 8) b = WRITE_REQ_ID;
      else begin
        b = 8'($urandom_range(255));
        if (b == READ_REQ_ID || b == WRITE_REQ_ID) b = 8'h55;
      end
      pushReq(b, $urandom_range(4, 1), 8'($urandom_range(16, 1)), 2);
    end
    for (int i = 0; i < 30; i++) begin
      pushResp(0, $urandom_range(3, 1), 8'($urandom_range(16, 1)), 0, 2);
      pushResp(1, $urandom_range(3, 1), 8'($urandom_range(16, 1)), 0, 2);
    end
    waitIdle(5000);
    randStops = 0;
    tick(2);
    chk("random_dropCount", dropCount, expDrop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
